// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: sequential pc, prefetch FIFO, valid/ready to decode
module fetch_unit #(
    parameter int ISIZE  = 17,
    parameter int AWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH:0]   prog_len,
    input  logic              flush,
    input  logic [AWIDTH-1:0] flush_pc,
    output logic              imem_req,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic [ISIZE-1:0]  imem_rdata,
    input  logic              imem_valid,
    output logic [ISIZE-1:0]  inst,
    output logic [AWIDTH-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AWIDTH:0] PC_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH:0]   pc_q, pc_d;
    logic              outst_q, outst_d;
    logic              discard_q, discard_d;
    logic [ISIZE-1:0]  fifo_data_q [DEPTH];
    logic [AWIDTH-1:0] fifo_pc_q   [DEPTH];
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     count_q, count_d, occ_after_pop;
    logic              imem_req_q, imem_req_d;
    logic [AWIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [ISIZE-1:0]  inst_q, inst_d;
    logic [AWIDTH-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              halted_q, halted_d;

    logic              active, do_flush, resp, push, pop, mem_free, issue;
    logic [AWIDTH:0]   issue_pc;

    always_comb begin
        active   = (state_q == S_RUN) || (state_q == S_DRAIN);
        do_flush = flush && active;
        pop      = inst_valid_q && inst_ready;
        resp     = imem_valid && outst_q;
        push     = resp && !discard_q && !do_flush;
        // memory port is free for a new request once any outstanding one returns this cycle
        mem_free = !outst_q || imem_valid;

        occ_after_pop = count_q - CW'(pop);
        if (do_flush) begin
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            count_d = occ_after_pop + CW'(push);
            rd_d    = rd_q + PW'(pop);
            wr_d    = wr_q + PW'(push);
        end

        issue    = 1'b0;
        issue_pc = pc_q;
        state_d  = state_q;
        halted_d = halted_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    halted_d = 1'b0;
                    issue_pc = '0;
                    issue    = (prog_len != '0);
                end
            end
            S_RUN, S_DRAIN: begin
                if (do_flush) begin
                    state_d  = S_RUN;
                    issue_pc = {1'b0, flush_pc};
                    issue    = mem_free && (issue_pc < prog_len);
                end else if (state_q == S_RUN) begin
                    issue = mem_free && (pc_q < prog_len) && (count_d < CW'(DEPTH));
                    if (!issue && (pc_q >= prog_len)) begin
                        state_d = S_DRAIN;
                    end
                end else if ((count_d == '0) && mem_free) begin
                    state_d  = S_DONE;
                    halted_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pc_d        = issue ? issue_pc + PC_ONE : issue_pc;
        outst_d     = issue ? 1'b1 : (resp ? 1'b0 : outst_q);
        discard_d   = resp ? 1'b0 : ((do_flush && outst_q) ? 1'b1 : discard_q);
        imem_req_d  = issue;
        imem_addr_d = issue ? issue_pc[AWIDTH-1:0] : imem_addr_q;

        // head register tracks the post-update FIFO head, bypassing a push into an empty FIFO
        inst_valid_d = (count_d != '0);
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        if (!do_flush) begin
            if (push && (occ_after_pop == '0)) begin
                inst_d    = imem_rdata;
                inst_pc_d = imem_addr_q;
            end else if (count_d != '0) begin
                inst_d    = fifo_data_q[rd_d];
                inst_pc_d = fifo_pc_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_q] <= imem_rdata;
            fifo_pc_q[wr_q]   <= imem_addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            outst_q      <= 1'b0;
            discard_q    <= 1'b0;
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign halted     = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with memory responder and program-order scoreboard
module tb_fetch_unit;
    localparam int ISIZE  = 17;
    localparam int AWIDTH = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AWIDTH:0]   prog_len = '0;
    logic              flush = 1'b0;
    logic [AWIDTH-1:0] flush_pc = '0;
    logic              imem_req;
    logic [AWIDTH-1:0] imem_addr;
    logic [ISIZE-1:0]  imem_rdata = '0;
    logic              imem_valid = 1'b0;
    logic [ISIZE-1:0]  inst;
    logic [AWIDTH-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic              halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ISIZE-1:0] mem [256];
    int   exp_q[$];
    int   cur_len = 0, lat_lo = 1, lat_hi = 1, ready_pct = 100, flush_pct = 0;
    int   req_cnt = 0, resp_cnt = 0, cnt = 0;
    bit   pend = 1'b0;
    bit   strict_halt = 1'b0;
    logic [AWIDTH-1:0] paddr = '0;

    fetch_unit #(.ISIZE(ISIZE), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
        .flush(flush), .flush_pc(flush_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // instruction memory: one response per request after a random latency in [lat_lo, lat_hi]
    always @(negedge clk) begin
        imem_valid = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt <= 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem[paddr];
                pend = 1'b0;
                resp_cnt++;
            end
        end
        if (imem_req === 1'b1) begin
            req_cnt++;
            chk("single_outstanding", pend, 0);
            chk("req_below_len", int'(imem_addr) < cur_len, 1);
            pend  = 1'b1;
            cnt   = $urandom_range(lat_hi, lat_lo);
            paddr = imem_addr;
        end
    end

    task automatic rand_ready();
        inst_ready = ($urandom_range(99) < ready_pct);
    endtask

    task automatic cycle(input bit do_fl, input logic [AWIDTH-1:0] fpc);
        int e;
        if (do_fl) begin
            flush    = 1'b1;
            flush_pc = fpc;
        end
        if (inst_valid === 1'b1 && inst_ready) begin
            strict_halt = !pend;
            if (exp_q.size() == 0) begin
                chk("extra_inst_pc", inst_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e);
                chk("inst", inst, mem[e]);
                chk("halted_low", halted, 0);
            end
        end
        if (do_fl) begin
            strict_halt = 1'b0;
            exp_q.delete();
            for (int a = int'(fpc); a < cur_len; a++) exp_q.push_back(a);
        end
        @(negedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
    endtask

    task automatic start_prog(input int len);
        cur_len  = len;
        prog_len = (AWIDTH+1)'(len);
        exp_q.delete();
        for (int a = 0; a < len; a++) exp_q.push_back(a);
        req_cnt  = 0;
        resp_cnt = 0;
        start    = 1'b1;
        rand_ready();
        cycle(1'b0, '0);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        bit f;
        logic [AWIDTH-1:0] fpc;
        n = 0;
        strict_halt = 1'b0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            f   = 1'b0;
            fpc = '0;
            rand_ready();
            if (flush_pct > 0 && $urandom_range(99) < flush_pct) begin
                f   = 1'b1;
                fpc = AWIDTH'($urandom_range(cur_len, 0));
            end
            cycle(f, fpc);
            n++;
        end
        chk("drain_in_time", exp_q.size(), 0);
        if (strict_halt) begin
            chk("halted_after_last_pop", halted, 1);
        end else begin
            n = 0;
            while (halted !== 1'b1 && n < 20) begin
                cycle(1'b0, '0);
                n++;
            end
            chk("halted_eventually", halted, 1);
        end
        chk("no_valid_when_done", inst_valid, 0);
    endtask

    initial begin
        int n;
        int bad;
        int len;
        for (int i = 0; i < 256; i++) mem[i] = ISIZE'(17'h10000 + i);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_halted", halted, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // basic run, latency 1, always ready
        lat_lo = 1; lat_hi = 1; ready_pct = 100; flush_pct = 0;
        start_prog(3);
        chk("start_req", imem_req, 1);
        chk("start_addr", imem_addr, 0);
        drain(60);
        repeat (4) cycle(1'b0, '0);
        chk("basic_req_count", req_cnt, 3);

        // backpressure: credit limit holds requests at DEPTH
        for (int i = 0; i < 256; i++) mem[i] = ISIZE'($urandom);
        ready_pct = 0;
        start_prog(8);
        repeat (30) begin rand_ready(); cycle(1'b0, '0); end
        chk("bp_req_count", req_cnt, DEPTH);
        chk("bp_valid", inst_valid, 1);
        chk("bp_head_pc", inst_pc, 0);
        chk("bp_head", inst, mem[0]);
        ready_pct = 60;
        drain(300);
        chk("bp_total_req", req_cnt, 8);

        // flush while address 2 is in flight
        lat_lo = 3; lat_hi = 3; ready_pct = 100;
        start_prog(10);
        n = 0;
        while (!(pend && paddr == 8'd2) && n < 60) begin rand_ready(); cycle(1'b0, '0); n++; end
        chk("inflight_seen", pend && paddr == 8'd2, 1);
        rand_ready();
        cycle(1'b1, 8'd5);
        chk("flush_clears_valid", inst_valid, 0);
        drain(200);
        chk("inflight_req_count", req_cnt, 8);

        // flush coincident with a response, two entries buffered
        lat_lo = 2; lat_hi = 2; ready_pct = 0;
        start_prog(6);
        n = 0;
        while (!(resp_cnt == 3 && imem_valid === 1'b1) && n < 60) begin inst_ready = 1'b0; cycle(1'b0, '0); n++; end
        chk("occ2_seen", resp_cnt == 3 && imem_valid === 1'b1, 1);
        inst_ready = 1'b0;
        cycle(1'b1, 8'd1);
        chk("simul_flush_valid", inst_valid, 0);
        ready_pct = 100;
        drain(200);
        chk("simul_req_count", req_cnt, 8);

        // asynchronous reset with three buffered and one outstanding
        lat_lo = 3; lat_hi = 3; ready_pct = 0;
        start_prog(10);
        n = 0;
        while (!(resp_cnt == 3 && pend) && n < 60) begin inst_ready = 1'b0; cycle(1'b0, '0); n++; end
        chk("pre_reset_state", resp_cnt == 3 && pend, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_imem_req", imem_req, 0);
        chk("mid_rst_imem_addr", imem_addr, 0);
        chk("mid_rst_inst", inst, 0);
        chk("mid_rst_inst_pc", inst_pc, 0);
        chk("mid_rst_inst_valid", inst_valid, 0);
        chk("mid_rst_halted", halted, 0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            inst_ready = 1'b1;
            cycle(1'b0, '0);
            if (imem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0) bad++;
        end
        chk("idle_after_reset", bad, 0);
        lat_lo = 1; lat_hi = 4; ready_pct = 70;
        start_prog(5);
        drain(200);

        // empty program
        start_prog(0);
        n = 1;
        while (halted !== 1'b1 && n < 3) begin cycle(1'b0, '0); n++; end
        chk("len0_halted", halted, 1);
        chk("len0_no_req", req_cnt, 0);

        // randomized programs with latency, backpressure and redirects
        repeat (8) begin
            for (int i = 0; i < 256; i++) mem[i] = ISIZE'($urandom);
            lat_lo    = $urandom_range(2, 1);
            lat_hi    = lat_lo + $urandom_range(3, 0);
            ready_pct = $urandom_range(100, 20);
            flush_pct = $urandom_range(1, 0) * $urandom_range(8, 1);
            len       = $urandom_range(40, 1);
            start_prog(len);
            drain(3000);
            if (flush_pct == 0) chk("rand_req_count", req_cnt, len);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the FPU pipeline. Reads 17-bit instruction words from instruction memory with a sequential program counter, buffers them in a small prefetch FIFO, and presents them to the decode stage over a valid/ready handshake. Supports program start, pipeline flush/redirect, and end-of-program drain and halt.

## Interface
- ISIZE, 17, instruction width; matches the decode field split RL[16:12], RR[11:7], RD[6:2], Op[1:0]
- AWIDTH, 8, instruction memory address width
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: begin fetching at address 0
- prog_len  in  AWIDTH+1  number of instructions in program; sampled each cycle
- flush  in  1  single-cycle pulse: discard buffered/in-flight instructions and redirect
- flush_pc  in  AWIDTH  redirect target, valid with flush
- imem_req  out  1  single-cycle read request
- imem_addr  out  AWIDTH  read address; held from request until response
- imem_rdata  in  ISIZE  read data, valid with imem_valid
- imem_valid  in  1  response strobe; ≥1 cycle after imem_req
- inst  out  ISIZE  FIFO head instruction, to decode
- inst_pc  out  AWIDTH  address of inst
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  decode accepts; transfer when inst_valid && inst_ready
- halted  out  1  program complete, all instructions consumed

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE: no requests. start → RUN, pc←0, halted←0. flush ignored in IDLE/DONE.
- RUN: issue imem_req (addr = pc) when no request outstanding, pc < prog_len, and (occupancy + outstanding) < DEPTH; pc increments on issue. At most one outstanding request.
- RUN → DRAIN when pc ≥ prog_len and no request issued that cycle. prog_len = 0 at start: RUN → DRAIN → DONE with no requests.
- DRAIN → DONE when no request outstanding and FIFO empty; halted←1 on entry to DONE.
- Response: on imem_valid with an outstanding, non-discarded request, push {imem_rdata, imem_addr} into FIFO; outstanding cleared.
- Pop on inst_valid && inst_ready. Push and pop in the same cycle allowed; occupancy unchanged.
- Credit rule guarantees no push into a full FIFO; imem_valid with nothing outstanding is ignored.
- flush (RUN/DRAIN): FIFO emptied, pc←flush_pc, state←RUN. If a request is outstanding, its response is discarded (discard flag set until that imem_valid arrives); no new request until it returns. imem_valid in the same cycle as flush is discarded. flush overrides a same-cycle pop (the popped instruction still counts as consumed by decode).
- start while in RUN/DRAIN is ignored.
- pc counter internally AWIDTH+1 bits; imem_addr = pc[AWIDTH-1:0]. No wrap: fetching stops at prog_len.

## Timing
- Reset values: imem_req 0, imem_addr 0, inst 0, inst_pc 0, inst_valid 0, halted 0; FIFO empty, pc 0, no outstanding request.
- All outputs registered.
- start in cycle T → imem_req=1, imem_addr=0 in cycle T+1.
- Memory response in cycle R → inst_valid=1 in cycle R+1 (if FIFO was empty).
- Next request may issue the cycle after imem_valid: throughput is one instruction per (memory latency + 1) cycles.
- inst/inst_pc are stable while inst_valid && !inst_ready.
- flush in cycle F → inst_valid=0 in F+1. Earliest redirect request in F+1 if nothing is outstanding.
- halted rises the cycle after the last pop when nothing is outstanding.

## Test plan
- Basic run: prog_len=3, memory latency 1, mem[i]=0x1_0000+i, inst_ready=1 → inst sequence 0x10000, 0x10001, 0x10002 with inst_pc 0,1,2; halted=1 after the third accept; no fourth imem_req.
- Backpressure: prog_len=8, inst_ready=0 → exactly DEPTH=4 requests issued, inst holds mem[0]; release → all 8 delivered in order, none lost or duplicated.
- Flush with in-flight request: latency 3, flush with flush_pc=5 while addr 2 is outstanding → addr-2 data never appears; next inst_pc=5.
- Simultaneous flush and imem_valid: FIFO occupancy 2 → inst_valid=0 next cycle; the response is dropped; fetch resumes at flush_pc.
- Reset mid-run: assert rst_n=0 with FIFO 3 full and a request outstanding → all outputs at reset values immediately; late imem_valid after reset is ignored; IDLE until start.
- prog_len=0: start → no imem_req; halted=1 within 3 cycles.
